rtc_access_scheduler: RTL and testbench
=======================================

// Module: rtc_access_scheduler
// PURPOSE
//  Sequences the V3023 bus engine (ciclo/Fin handshake). Periodically sweeps the six time/date registers into
//  coherent shadow outputs for the display path. Interleaves one-shot user writes (time set) between read slots.
//  Sits between the user-input FSM and the bus engine; owns all RTC traffic.
// PARAMETERS
//  REFRESH_CYCLES  1000000  Clock_in cycles between sweep requests (10 ms at 100 MHz)
//  TIMEOUT_CYCLES  255      max cycles waiting for Fin before a slot aborts
//  BASE_ADDR       8'h21    RTC address of slot 0; slots 0..5 = seg,min,hora,dia,mes,anio at BASE_ADDR+idx
// PORTS
//  Clock_in     in   1  100 MHz clock
//  Reset        in   1  synchronous, active-high
//  wr_req       in   1  user write request (level, held until wr_ack)
//  wr_addr      in   8  RTC address for user write
//  wr_data      in   8  data for user write
//  wr_ack       out  1  1-cycle pulse: request latched
//  wr_done      out  1  1-cycle pulse: user write completed (Fin seen)
//  ciclo        out  1  1-cycle start pulse to bus engine
//  Fin          in   1  1-cycle done pulse from bus engine
//  bus_dir      out  1  1 = write slot, 0 = read slot
//  bus_addr     out  8  address presented to bus engine
//  bus_wdata    out  8  write data presented to bus engine
//  bus_rdata    in   8  read data from bus engine, valid in the Fin cycle
//  seg,min,hora,dia,mes,anio  out 8 each  published time registers
//  time_valid   out  1  1-cycle pulse when a new sweep is published
//  err          out  1  sticky timeout flag; cleared only by Reset
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; refresh counter, idx, timeout counter = 0; sweep_pending = 0; write latch empty.
//  Refresh counter: free-runs 0..REFRESH_CYCLES-1. At wrap, set sweep_pending. Re-setting while already pending is a no-op.
//  wr_ack: pulses the cycle after wr_req is high, latch empty, and state != ISSUE/WAIT.
//   - Latches wr_addr/wr_data. Latch stays full until its write slot ends.
//  FSM: IDLE -> ISSUE -> WAIT -> IDLE.
//   - IDLE arbitration: write latch full wins; else sweep_pending/active read slot idx; else stay.
//   - ISSUE (1 cycle): ciclo=1. bus_dir/addr/wdata are set here and held constant until leaving WAIT.
//   - WAIT: wait for Fin; the timeout counter increments each cycle.
//     - Fin on a read slot: bus_rdata -> shadow[idx].
//       - idx<5: idx+1.
//       - idx==5: copy all 6 shadows to outputs in one cycle, pulse time_valid, clear sweep_pending, idx=0.
//     - Fin on a write slot: pulse wr_done and empty the latch.
//     - In all cases: -> IDLE.
//  A write interleaves between read slots. The sweep resumes at the same idx afterwards. Min 1 IDLE cycle between slots.
//  Timeout (counter == TIMEOUT_CYCLES with no Fin):
//   - set err; abort slot; -> IDLE.
//   - read: discard sweep (outputs unchanged), idx=0, clear sweep_pending.
//   - write: empty the latch, no wr_done.
//  Fin outside WAIT: ignored. Reset mid-slot: immediate return to reset values; ciclo never re-pulses for the aborted slot.
//  Published outputs change only at sweep completion, never partially.
// TESTING
//  1. Reset, then 1 refresh period; bus model returns 8'h10+idx with Fin 60 cycles after ciclo.
//     -> six reads at addr 21..26, seg..anio = 10..15, one time_valid.
//  2. wr_req (addr 8'h22, data 8'h45) during the slot 2 read.
//     -> wr_ack; write issued after slot 2 Fin; sweep resumes at idx 3; wr_done once.
//  3. Bus model withholds Fin on slot 4.
//     -> after TIMEOUT_CYCLES err=1, no time_valid, outputs keep previous sweep; next refresh sweeps from idx 0.
//  4. Reset asserted in WAIT of slot 1. -> ciclo=0 and all outputs 0 the next cycle; no time_valid, no wr_done.
//  5. Refresh wrap during an active sweep. -> exactly one extra sweep follows; spurious Fin in IDLE is ignored.

Source files
------------

// File: rtl/rtc_access_scheduler.sv
// Schedules all V3023 RTC bus traffic: periodic six-register read sweeps published
// atomically to shadow outputs, with one-shot user writes interleaved between read slots.
module rtc_access_scheduler #(
  parameter int unsigned REFRESH_CYCLES = 1000000,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [7:0]  BASE_ADDR      = 8'h21
) (
  input  logic       Clock_in,
  input  logic       Reset,
  input  logic       wr_req,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       wr_ack,
  output logic       wr_done,
  output logic       ciclo,
  input  logic       Fin,
  output logic       bus_dir,
  output logic [7:0] bus_addr,
  output logic [7:0] bus_wdata,
  input  logic [7:0] bus_rdata,
  output logic [7:0] seg,
  output logic [7:0] min,
  output logic [7:0] hora,
  output logic [7:0] dia,
  output logic [7:0] mes,
  output logic [7:0] anio,
  output logic       time_valid,
  output logic       err
);

  localparam int unsigned REF_W   = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int unsigned TO_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int unsigned N_SLOTS = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t          state;
  logic [REF_W-1:0] ref_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic [2:0]       idx;
  logic [7:0]       shadow [N_SLOTS];
  logic             slot_wr;
  logic             sweep_pending;
  logic             sweep_busy;
  logic             sweep_again;
  logic             lat_full;
  logic [7:0]       lat_addr;
  logic [7:0]       lat_data;
  logic             ref_wrap;
  logic             wr_accept;

  assign ref_wrap  = (ref_cnt == REF_W'(REFRESH_CYCLES - 1));
  assign wr_accept = wr_req && !lat_full && (state == IDLE);

  // Free-running refresh period counter
  always_ff @(posedge Clock_in) begin
    if (Reset) begin
      ref_cnt <= '0;
    end else if (ref_wrap) begin
      ref_cnt <= '0;
    end else begin
      ref_cnt <= ref_cnt + REF_W'(1);
    end
  end

  // Slot sequencer, write latch, sweep bookkeeping and published outputs
  always_ff @(posedge Clock_in) begin
    if (Reset) begin
      state         <= IDLE;
      to_cnt        <= '0;
      idx           <= '0;
      slot_wr       <= 1'b0;
      sweep_pending <= 1'b0;
      sweep_busy    <= 1'b0;
      sweep_again   <= 1'b0;
      lat_full      <= 1'b0;
      lat_addr      <= '0;
      lat_data      <= '0;
      wr_ack        <= 1'b0;
      wr_done       <= 1'b0;
      ciclo         <= 1'b0;
      bus_dir       <= 1'b0;
      bus_addr      <= '0;
      bus_wdata     <= '0;
      seg           <= '0;
      min           <= '0;
      hora          <= '0;
      dia           <= '0;
      mes           <= '0;
      anio          <= '0;
      time_valid    <= 1'b0;
      err           <= 1'b0;
      for (int i = 0; i < N_SLOTS; i++) begin
        shadow[i] <= '0;
      end
    end else begin
      wr_ack     <= 1'b0;
      wr_done    <= 1'b0;
      ciclo      <= 1'b0;
      time_valid <= 1'b0;

      if (wr_accept) begin
        lat_full <= 1'b1;
        lat_addr <= wr_addr;
        lat_data <= wr_data;
        wr_ack   <= 1'b1;
      end

      // A wrap during a running sweep is remembered as exactly one follow-up sweep
      if (ref_wrap) begin
        if (sweep_busy) begin
          sweep_again <= 1'b1;
        end else begin
          sweep_pending <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (lat_full || wr_accept) begin
            state     <= ISSUE;
            ciclo     <= 1'b1;
            slot_wr   <= 1'b1;
            bus_dir   <= 1'b1;
            bus_addr  <= lat_full ? lat_addr : wr_addr;
            bus_wdata <= lat_full ? lat_data : wr_data;
          end else if (sweep_pending) begin
            state      <= ISSUE;
            ciclo      <= 1'b1;
            slot_wr    <= 1'b0;
            bus_dir    <= 1'b0;
            bus_addr   <= BASE_ADDR + 8'(idx);
            sweep_busy <= 1'b1;
          end
        end

        ISSUE: begin
          state  <= WAIT;
          to_cnt <= '0;
        end

        WAIT: begin
          if (Fin) begin
            state <= IDLE;
            if (slot_wr) begin
              wr_done  <= 1'b1;
              lat_full <= 1'b0;
            end else begin
              shadow[idx] <= bus_rdata;
              if (idx == 3'(N_SLOTS - 1)) begin
                seg           <= shadow[0];
                min           <= shadow[1];
                hora          <= shadow[2];
                dia           <= shadow[3];
                mes           <= shadow[4];
                anio          <= bus_rdata;
                time_valid    <= 1'b1;
                idx           <= '0;
                sweep_busy    <= 1'b0;
                sweep_again   <= 1'b0;
                sweep_pending <= sweep_again || ref_wrap;
              end else begin
                idx <= idx + 3'd1;
              end
            end
          end else if (to_cnt == TO_W'(TIMEOUT_CYCLES)) begin
            state <= IDLE;
            err   <= 1'b1;
            if (slot_wr) begin
              lat_full <= 1'b0;
            end else begin
              // Partial sweep is discarded; a wrap landing this very cycle still counts
              idx           <= '0;
              sweep_busy    <= 1'b0;
              sweep_again   <= 1'b0;
              sweep_pending <= ref_wrap;
            end
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_access_scheduler.sv
// Directed bench for rtc_access_scheduler: bus responder model plus scoreboard queues
// for expected bus slots and expected published sweeps.
`timescale 1ns/1ps
module tb_rtc_access_scheduler;

  localparam int unsigned REFRESH = 1000;
  localparam int unsigned TIMEOUT = 255;
  localparam logic [7:0]  BASE    = 8'h21;

  logic       Clock_in = 1'b0;
  logic       Reset    = 1'b1;
  logic       wr_req   = 1'b0;
  logic [7:0] wr_addr  = '0;
  logic [7:0] wr_data  = '0;
  logic       wr_ack, wr_done, ciclo, bus_dir, time_valid, err;
  logic [7:0] bus_addr, bus_wdata;
  logic [7:0] bus_rdata = '0;
  logic [7:0] seg, min, hora, dia, mes, anio;
  logic       fin_bus  = 1'b0;
  logic       fin_spur = 1'b0;
  logic       Fin;

  assign Fin = fin_bus | fin_spur;

  rtc_access_scheduler #(
    .REFRESH_CYCLES(REFRESH),
    .TIMEOUT_CYCLES(TIMEOUT),
    .BASE_ADDR     (BASE)
  ) dut (
    .Clock_in  (Clock_in),
    .Reset     (Reset),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ack    (wr_ack),
    .wr_done   (wr_done),
    .ciclo     (ciclo),
    .Fin       (Fin),
    .bus_dir   (bus_dir),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .seg       (seg),
    .min       (min),
    .hora      (hora),
    .dia       (dia),
    .mes       (mes),
    .anio      (anio),
    .time_valid(time_valid),
    .err       (err)
  );

  always #5 Clock_in = ~Clock_in;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int tv_cnt = 0, wrd_cnt = 0, ack_cnt = 0, bus_ops = 0;
  int withheld_cyc = 0;
  int unsigned fin_latency = 60;
  logic [7:0] rdata_base    = 8'h10;
  logic [7:0] withhold_addr = 8'hFF;
  logic [7:0] last_fin_addr = 8'h00;

  logic [16:0] exp_bus[$];  // {dir, addr, wdata}
  logic [47:0] exp_tv[$];

  always @(posedge Clock_in) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] times();
    return {seg, min, hora, dia, mes, anio};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin @(posedge Clock_in); #1; end
  endtask

  task automatic push_reads(input int first, input int last);
    for (int i = first; i <= last; i++) exp_bus.push_back({1'b0, BASE + 8'(i), 8'h00});
  endtask

  task automatic wait_tv(input int target, input int budget, input string tag);
    int n = 0;
    while (tv_cnt < target && n < budget) begin tick(1); n++; end
    check(tag, 64'(tv_cnt), 64'(target));
  endtask

  // Bus engine model: answers each ciclo with Fin after fin_latency cycles
  initial begin : bus_model
    logic [7:0]  a;
    logic [16:0] e;
    logic        aborted;
    forever begin
      @(posedge Clock_in); #1;
      if (ciclo) begin
        bus_ops++;
        a = bus_addr;
        check("bus_op_expected", 64'(exp_bus.size() != 0), 64'd1);
        if (exp_bus.size() != 0) begin
          e = exp_bus.pop_front();
          if (e[16]) check("bus_write_slot", 64'({bus_dir, bus_addr, bus_wdata}), 64'(e));
          else       check("bus_read_slot",  64'({bus_dir, bus_addr}), 64'(e[16:8]));
        end
        if (a == withhold_addr) begin
          withheld_cyc = cyc;
        end else begin
          aborted = 1'b0;
          for (int k = 0; k < int'(fin_latency); k++) begin
            @(posedge Clock_in); #1;
            if (Reset) begin aborted = 1'b1; break; end
          end
          if (!aborted) begin
            check("bus_addr_held", 64'(bus_addr), 64'(a));
            bus_rdata     = bus_dir ? 8'hEE : rdata_base + (a - BASE);
            last_fin_addr = a;
            fin_bus       = 1'b1;
            @(posedge Clock_in); #1;
            fin_bus = 1'b0;
          end
        end
      end
    end
  end

  // Output monitor: sweep scoreboard and pulse counters
  initial begin : monitor
    forever begin
      @(posedge Clock_in); #1;
      if (time_valid) begin
        tv_cnt++;
        check("sweep_expected", 64'(exp_tv.size() != 0), 64'd1);
        if (exp_tv.size() != 0) check("sweep_values", 64'(times()), 64'(exp_tv.pop_front()));
      end
      if (wr_done) wrd_cnt++;
      if (wr_ack) begin
        ack_cnt++;
        check("ack_after_slot2_fin", 64'(last_fin_addr), 64'h23);
      end
    end
  end

  initial begin : stimulus
    int n;
    int tv0;
    int ops0;

    // Reset state
    tick(3);
    check("rst_ctrl", 64'({wr_ack, wr_done, ciclo, bus_dir, bus_addr, bus_wdata, time_valid, err}), 64'd0);
    check("rst_times", 64'(times()), 64'd0);
    Reset = 1'b0;

    // 1: first refresh sweep
    push_reads(0, 5);
    exp_tv.push_back(48'h101112131415);
    wait_tv(1, 3000, "t1_sweep_done");
    check("t1_err", 64'(err), 64'd0);

    // 2: user write requested during the slot 2 read
    rdata_base = 8'h30;
    push_reads(0, 2);
    exp_bus.push_back({1'b1, 8'h22, 8'h45});
    push_reads(3, 5);
    exp_tv.push_back(48'h303132333435);
    n = 0;
    while (!(ciclo && bus_addr == 8'h23) && n < 3000) begin tick(1); n++; end
    check("t2_slot2_seen", 64'(n < 3000), 64'd1);
    tick(5);
    wr_addr = 8'h22;
    wr_data = 8'h45;
    wr_req  = 1'b1;
    n = 0;
    while (!wr_ack && n < 500) begin tick(1); n++; end
    check("t2_ack_seen", 64'(wr_ack), 64'd1);
    wr_req = 1'b0;
    wait_tv(2, 1500, "t2_sweep_done");
    check("t2_ack_count", 64'(ack_cnt), 64'd1);
    check("t2_wr_done_count", 64'(wrd_cnt), 64'd1);
    check("t2_err", 64'(err), 64'd0);

    // 3: slot 4 never completes
    rdata_base    = 8'h50;
    withhold_addr = 8'h25;
    push_reads(0, 4);
    tv0 = tv_cnt;
    n = 0;
    while (!err && n < 3000) begin tick(1); n++; end
    check("t3_err_set", 64'(err), 64'd1);
    check("t3_timeout_latency", 64'(cyc - withheld_cyc), 64'(TIMEOUT + 2));
    check("t3_no_publish", 64'(tv_cnt), 64'(tv0));
    check("t3_times_kept", 64'(times()), 64'h303132333435);
    withhold_addr = 8'hFF;
    push_reads(0, 5);
    exp_tv.push_back(48'h505152535455);
    wait_tv(tv0 + 1, 1500, "t3_next_sweep");
    check("t3_err_sticky", 64'(err), 64'd1);

    // 4: reset while waiting on slot 1
    push_reads(0, 1);
    ops0 = bus_ops;
    n = 0;
    while (bus_ops < ops0 + 2 && n < 2000) begin tick(1); n++; end
    check("t4_slot1_seen", 64'(bus_ops), 64'(ops0 + 2));
    tick(10);
    Reset = 1'b1;
    tick(1);
    check("t4_rst_ctrl", 64'({wr_ack, wr_done, ciclo, bus_dir, bus_addr, bus_wdata, time_valid, err}), 64'd0);
    check("t4_rst_times", 64'(times()), 64'd0);
    tick(2);
    Reset = 1'b0;
    tv0 = tv_cnt;
    n   = wrd_cnt;
    tick(300);
    check("t4_no_time_valid", 64'(tv_cnt), 64'(tv0));
    check("t4_no_wr_done", 64'(wrd_cnt), 64'(n));

    // 5: refresh wraps during a slow sweep -> exactly one follow-up sweep
    fin_latency = 200;
    rdata_base  = 8'h70;
    push_reads(0, 5);
    push_reads(0, 5);
    exp_tv.push_back(48'h707172737475);
    exp_tv.push_back(48'h707172737475);
    wait_tv(tv0 + 1, 3000, "t5_slow_sweep");
    fin_latency = 60;
    wait_tv(tv0 + 2, 1000, "t5_extra_sweep");
    tick(20);
    fin_spur = 1'b1;
    tick(1);
    fin_spur = 1'b0;
    tick(270);
    check("t5_single_extra", 64'(tv_cnt), 64'(tv0 + 2));
    check("t5_times_after_spurious_fin", 64'(times()), 64'h707172737475);
    check("t5_err_clear", 64'(err), 64'd0);
    check("bus_queue_drained", 64'(exp_bus.size()), 64'd0);
    check("sweep_queue_drained", 64'(exp_tv.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
